// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the 5-stage MIPS pipeline.
// Issues in-order word fetches over a req/addr_ok/data_ok handshake with at
// most one accepted-but-unreturned request, buffers returned words in a
// 2-entry queue, presents the queue head to ID and applies branch redirects
// with delay-slot semantics.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   stall[5:0]        bit0 blocks new request issue, bit1 stalls ID (no pop)
//   br_bus[32:0]      {br_e, br_addr}; only looked at in a pop cycle
//   inst_req/addr     fetch request, held until inst_addr_ok
//   inst_addr_ok      request accepted this cycle
//   inst_data_ok      read data returned this cycle (in order)
//   inst_rdata        read data
//   if_to_id_bus      {ce, pc, inst} of the queue head
//   stallreq          high while the queue is empty
//
// state | meaning
// IDLE  | no request driven; wait for queue room and no unreturned fetch
// REQ   | inst_req high at fetch_pc, held until inst_addr_ok

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [32:0] br_bus,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [64:0] if_to_id_bus,
   output logic        stallreq
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t            state_q, state_n;
   logic [1:0][31:0]  q_pc, q_inst, qn_pc, qn_inst;
   logic [1:0]        q_cnt, qn_cnt;
   logic              out_q, out_n;
   logic              cancel_q, cancel_n;
   logic [31:0]       fetch_pc, resp_pc, pend_addr;
   logic              pend_q, kill_q;
   logic              ce, pop, push, accept, redirect, keep, issue_ok;
   logic              br_e;
   logic [31:0]       br_tgt;
   logic [2:0]        occ;
   logic              unused_ok;

   assign br_e      = br_bus[32];
   assign br_tgt    = {br_bus[31:2], 2'b00};
   assign unused_ok = ^{stall[5:2], br_bus[1:0]};

   assign ce       = (q_cnt != 2'd0);
   assign pop      = ce & ~stall[1];
   assign redirect = pop & br_e;
   assign accept   = inst_req & inst_addr_ok;
   assign push     = inst_data_ok & ~cancel_q;
   assign out_n    = (out_q & ~inst_data_ok) | accept;

   // Slots already claimed: queued words plus in-flight words that will land.
   assign occ      = {1'b0, q_cnt} + {2'b00, out_q} - {2'b00, cancel_q};
   // A new request may only be raised once the previous one has returned,
   // so inst_req never overlaps an unreturned fetch.
   assign issue_ok = ~stall[0] & (~out_q | inst_data_ok) & (occ < 3'(BUF_DEPTH));

   assign inst_addr    = inst_req ? fetch_pc : 32'd0;
   assign if_to_id_bus = {ce, q_pc[0], q_inst[0]};
   assign stallreq     = ~ce;

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_n;
   end

   always_comb begin
      state_n  = state_q;
      inst_req = 1'b0;
      case (state_q)
         IDLE: if (issue_ok) state_n = REQ;
         REQ: begin
            inst_req = 1'b1;
            if (inst_addr_ok) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Next queue contents: pop shifts, push appends. On a redirect only the
   // first surviving entry (the delay slot) is kept, which also covers data
   // for the delay slot arriving in the redirect cycle itself.
   always_comb begin
      qn_pc   = q_pc;
      qn_inst = q_inst;
      qn_cnt  = q_cnt;
      if (pop) begin
         qn_pc[0]   = q_pc[1];
         qn_inst[0] = q_inst[1];
         qn_cnt     = q_cnt - 2'd1;
      end
      if (push) begin
         qn_pc[qn_cnt[0]]   = resp_pc;
         qn_inst[qn_cnt[0]] = inst_rdata;
         qn_cnt             = qn_cnt + 2'd1;
      end
      keep = redirect & (qn_cnt != 2'd0);
      if (keep) qn_cnt = 2'd1;
   end

   always_comb begin
      cancel_n = cancel_q;
      if (inst_data_ok && cancel_q) cancel_n = 1'b0;
      if (accept && kill_q)         cancel_n = 1'b1;
      if (keep)                     cancel_n = out_n;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_pc      <= '0;
         q_inst    <= '0;
         q_cnt     <= 2'd0;
         out_q     <= 1'b0;
         cancel_q  <= 1'b0;
         fetch_pc  <= RESET_PC;
         resp_pc   <= 32'd0;
         pend_q    <= 1'b0;
         pend_addr <= 32'd0;
         kill_q    <= 1'b0;
      end else begin
         q_pc     <= qn_pc;
         q_inst   <= qn_inst;
         q_cnt    <= qn_cnt;
         out_q    <= out_n;
         cancel_q <= cancel_n;
         if (accept) begin
            resp_pc  <= fetch_pc;
            fetch_pc <= pend_q ? pend_addr : fetch_pc + 32'd4;
            pend_q   <= 1'b0;
            kill_q   <= 1'b0;
         end
         // inst_addr is fetch_pc, so while a request waits for accept the
         // target is parked and swapped in at accept. With nothing in flight
         // the next fetch is the delay slot, so the target is parked as well.
         if (redirect) begin
            if (keep ? (inst_req & ~inst_addr_ok) : ~out_n) begin
               pend_q    <= 1'b1;
               pend_addr <= br_tgt;
               if (keep) kill_q <= 1'b1;
            end else begin
               fetch_pc <= br_tgt;
               pend_q   <= 1'b0;
               kill_q   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by a randomized run.
// The reference model tracks the program-order instruction stream ID should
// see (sequential PCs, one delay slot after a taken branch, then the target)
// plus handshake invariants; memory is a single-outstanding responder with
// randomized accept and latency.

module tb_if_fetch_unit;

   localparam logic [31:0] RPC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  stall = '0;
   logic [32:0] br_bus = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic [64:0] if_to_id_bus;
   logic        stallreq;

   if_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata), .if_to_id_bus(if_to_id_bus),
      .stallreq(stallreq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // knobs
   int ok_pct, lat_min, lat_max, st0_pct, st1_pct, br_pct;
   int hold_n, blk_n;
   logic [31:0] hold_pc, blk_addr, fbr_pc, fbr_tgt, never_pc;
   logic fbr_en, never_en, saw_never;

   // memory and stream model
   logic        mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;
   logic [31:0] exp_pc, slot_tgt;
   logic        slot_pending;
   logic        prev_hold, prev_req, prev_acc;
   logic [64:0] prev_bus;
   logic [31:0] prev_addr;
   int          cyc, first_ce, first_acc;
   logic [31:0] acc_q[$];
   logic [31:0] pop_q[$];

   function automatic logic [31:0] f(logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [31:0] pq(int i);
      if (i < pop_q.size()) return pop_q[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] aq(int i);
      if (i < acc_q.size()) return acc_q[i];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic knobs(int ok, int lmin, int lmax, int s0, int s1, int br);
      ok_pct = ok; lat_min = lmin; lat_max = lmax;
      st0_pct = s0; st1_pct = s1; br_pct = br;
      hold_n = 0; blk_n = 0; hold_pc = '0; blk_addr = '0;
      fbr_en = 0; fbr_pc = '0; fbr_tgt = '0;
      never_en = 0; never_pc = '0; saw_never = 0;
   endtask

   // Called at a negedge; holds reset for n posedges, checks, releases.
   task automatic do_reset(int n);
      rst = 1'b0; inst_addr_ok = 0; inst_data_ok = 0; stall = '0; br_bus = '0;
      repeat (n) @(negedge clk);
      chk("rst_bus", if_to_id_bus, 65'd0);
      chk("rst_req", inst_req, 0);
      chk("rst_addr", inst_addr, 0);
      chk("rst_stallreq", stallreq, 1);
      rst = 1'b1;
      mem_busy = 0; mem_cnt = 0; mem_addr = '0;
      exp_pc = RPC; slot_pending = 0; slot_tgt = '0;
      prev_hold = 0; prev_req = 0; prev_acc = 0; prev_bus = '0; prev_addr = '0;
      acc_q.delete(); pop_q.delete();
      cyc = 0; first_ce = -1; first_acc = -1;
   endtask

   task automatic step();
      logic        was_busy, s0, s1, do_pop, b, forced;
      logic [64:0] bus;
      logic [31:0] pc;
      @(negedge clk);
      cyc++;
      bus = if_to_id_bus;
      pc  = bus[63:32];
      chk("stallreq", stallreq, !bus[64]);
      if (prev_hold) chk("hold_bus", bus, prev_bus);
      if (prev_req && !prev_acc) begin
         chk("req_held", inst_req, 1);
         chk("addr_held", inst_addr, prev_addr);
      end
      if (bus[64] && first_ce < 0) first_ce = cyc;
      if (never_en && bus[64] && pc == never_pc) saw_never = 1;

      was_busy = mem_busy;
      inst_data_ok = 0;
      inst_rdata = $urandom;
      if (mem_busy) begin
         if (mem_cnt <= 1) begin
            inst_data_ok = 1; inst_rdata = f(mem_addr); mem_busy = 0;
         end else mem_cnt--;
      end
      if (inst_req) begin
         chk("req_outstanding", was_busy && !inst_data_ok, 0);
         chk("addr_align", inst_addr[1:0], 0);
      end
      inst_addr_ok = ($urandom_range(99) < ok_pct);
      if (blk_n > 0 && inst_req && inst_addr == blk_addr) begin
         inst_addr_ok = 0; blk_n--;
      end
      if (inst_req && inst_addr_ok) begin
         mem_busy = 1; mem_addr = inst_addr;
         mem_cnt = $urandom_range(lat_max, lat_min);
         acc_q.push_back(inst_addr);
         if (first_acc < 0) first_acc = cyc;
      end

      s0 = ($urandom_range(99) < st0_pct);
      s1 = ($urandom_range(99) < st1_pct);
      if (hold_n > 0 && bus[64] && (hold_pc == 0 || pc == hold_pc)) begin
         s1 = 1; hold_n--;
      end
      stall = {4'($urandom), s1, s0};

      do_pop = bus[64] && !s1;
      if (do_pop) begin
         forced = fbr_en && pc == fbr_pc;
         b = !slot_pending && (forced || ($urandom_range(99) < br_pct));
         br_bus = {b, forced ? fbr_tgt : $urandom};
         chk("pop_pc", pc, exp_pc);
         chk("pop_inst", bus[31:0], f(exp_pc));
         pop_q.push_back(pc);
         if (slot_pending) begin
            exp_pc = slot_tgt; slot_pending = 0;
         end else if (b) begin
            slot_tgt = {br_bus[31:2], 2'b00}; slot_pending = 1;
            exp_pc = exp_pc + 32'd4;
         end else exp_pc = exp_pc + 32'd4;
      end else br_bus = {1'($urandom), $urandom};

      prev_hold = bus[64] && s1;
      prev_bus  = bus;
      prev_req  = inst_req;
      prev_acc  = inst_req && inst_addr_ok;
      prev_addr = inst_addr;
   endtask

   initial begin
      int n;
      knobs(100, 1, 1, 0, 0, 0);
      @(negedge clk);
      do_reset(3);

      // sequential fetch, latency 1, no stalls
      for (int i = 0; i < 20 && first_ce < 0; i++) step();
      chk("first_ce_latency", 65'(first_ce - first_acc), 65'd2);
      n = pop_q.size();
      repeat (20) step();
      chk("rate_1_per_2", 65'(pop_q.size() - n), 65'd10);
      chk("acc0", aq(0), RPC);
      chk("acc1", aq(1), RPC + 32'd4);
      chk("acc2", aq(2), RPC + 32'd8);

      // ID stall with ce=1 for 6 cycles, then back-to-back delivery
      hold_n = 6; hold_pc = '0;
      for (int i = 0; i < 40 && hold_n > 0; i++) step();
      chk("hold_done", hold_n, 0);
      chk("full_no_req", inst_req, 0);
      chk("full_ce", if_to_id_bus[64], 1);
      n = pop_q.size();
      step(); step();
      chk("back_to_back", 65'(pop_q.size() - n), 65'd2);

      // branch at 08 with 0C already queued
      do_reset(1);
      knobs(100, 1, 1, 0, 0, 0);
      hold_n = 6; hold_pc = RPC + 32'h8;
      fbr_en = 1; fbr_pc = RPC + 32'h8; fbr_tgt = RPC + 32'h103;
      never_en = 1; never_pc = RPC + 32'h10;
      for (int i = 0; i < 80 && pop_q.size() < 6; i++) step();
      chk("br_q_pop2", pq(2), RPC + 32'h8);
      chk("br_q_pop3", pq(3), RPC + 32'hC);
      chk("br_q_pop4", pq(4), RPC + 32'h100);
      chk("br_q_never10", saw_never, 0);

      // branch at 08 with 0C in flight, latency 3
      do_reset(1);
      knobs(100, 3, 3, 0, 0, 0);
      fbr_en = 1; fbr_pc = RPC + 32'h8; fbr_tgt = RPC + 32'h100;
      for (int i = 0; i < 100 && pop_q.size() < 5; i++) step();
      chk("br_o_acc3", aq(3), RPC + 32'hC);
      chk("br_o_acc4", aq(4), RPC + 32'h100);
      chk("br_o_pop3", pq(3), RPC + 32'hC);
      chk("br_o_pop4", pq(4), RPC + 32'h100);

      // branch while the delay-slot request waits 4 cycles for accept
      do_reset(1);
      knobs(100, 1, 1, 0, 0, 0);
      blk_n = 4; blk_addr = RPC + 32'h4;
      fbr_en = 1; fbr_pc = RPC; fbr_tgt = RPC + 32'h200;
      for (int i = 0; i < 60 && pop_q.size() < 3; i++) step();
      chk("wait_blocked", blk_n, 0);
      chk("wait_acc1", aq(1), RPC + 32'h4);
      chk("wait_acc2", aq(2), RPC + 32'h200);
      chk("wait_pop1", pq(1), RPC + 32'h4);
      chk("wait_pop2", pq(2), RPC + 32'h200);

      // reset with a response outstanding
      do_reset(1);
      knobs(100, 3, 3, 0, 0, 0);
      for (int i = 0; i < 10 && !mem_busy; i++) step();
      chk("rst_mid_outstanding", mem_busy, 1);
      do_reset(1);
      for (int i = 0; i < 10 && acc_q.size() < 1; i++) step();
      chk("rst_mid_first_req", aq(0), RPC);

      // randomized run
      do_reset(1);
      knobs(60, 1, 4, 20, 30, 25);
      repeat (3000) step();
      chk("random_progress", 65'(pop_q.size() >= 100), 65'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
